pri_decoder_buffered: RTL
=========================

PRI_DECODER_BUFFERED -- requirements
Module: pri_decoder_buffered

Interface
REQ-001 The block SHALL have no parameters; the code width is fixed at 4 and the one-hot output width at 16.
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  when low, blocks new input acceptance; stored entries still drain.
REQ-005 binary_in  input  4  binary code to decode, 0..15.
REQ-006 in_valid  input  1  binary_in is valid this cycle.
REQ-007 in_ready  output  1  block can accept binary_in this cycle.
REQ-008 decoder_out  output  16  one-hot decode of the head entry.
REQ-009 out_valid  output  1  decoder_out holds a valid entry.
REQ-010 out_ready  input  1  consumer accepts decoder_out this cycle.
REQ-011 dec_count  output  8  saturating count of delivered outputs.

Function
REQ-012 The block SHALL buffer accepted codes in a 2-entry FIFO with 1-bit read and write pointers and a 2-bit occupancy (0..2).
REQ-013 Occupancy SHALL act as a state machine with states EMPTY(0), ONE(1) and FULL(2).
REQ-014 State transitions SHALL be:
- push only: +1
- pop only: -1
- push and pop together: unchanged
- neither: unchanged
REQ-015 in_ready SHALL equal enable AND (state != FULL), combinationally.
REQ-016 A push SHALL occur when in_valid AND in_ready are both high at a rising edge; binary_in is written at the write pointer, and the pointer toggles.
REQ-017 out_valid SHALL equal (state != EMPTY), driven from registered state only.
REQ-018 A pop SHALL occur when out_valid AND out_ready are both high at a rising edge; the read pointer toggles.
REQ-019 When out_valid is high, decoder_out SHALL equal 16'h0001 shifted left by the head code; otherwise it SHALL be 16'h0000.
REQ-020 Latency SHALL be exactly one cycle with no combinational input-to-output path: a code pushed into EMPTY at edge k appears with out_valid=1 in the cycle after edge k.
REQ-021 Codes SHALL be delivered in acceptance order, without loss or duplication.
REQ-022 In FULL, in_ready SHALL be 0 even if out_ready=1; there is no same-cycle pass-through.
REQ-023 In ONE with push and pop together, the old head SHALL be delivered and the new code SHALL become the head on the next cycle.
REQ-024 In EMPTY, out_ready SHALL have no effect.
REQ-025 In FULL, in_valid SHALL have no effect and held data SHALL be unchanged.
REQ-026 dec_count SHALL increment by 1 on each pop and hold at 255 once reached (no wrap-around).
REQ-027 enable deassertion SHALL NOT alter stored entries, out_valid, decoder_out or dec_count.
REQ-028 Holding decoder_out stable while out_valid=1 and out_ready=0 SHALL be guaranteed.

Reset
REQ-029 While reset_n is low, the block SHALL asynchronously force the following, independent of clk:
- state to EMPTY and both pointers to 0
- dec_count to 0, out_valid to 0, decoder_out to 16'h0000
REQ-030 While reset_n is low, in_ready SHALL be 0; after release it SHALL equal enable.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries, with no output of partial data after release.
REQ-032 FIFO storage contents need not be reset, but they SHALL never be visible while out_valid=0.

Verification
REQ-033 Basic decode: reset, enable=1, out_ready=1; push binary_in=4'd5 -> next cycle out_valid=1, decoder_out=16'h0020; one cycle later dec_count=1.
REQ-034 Backpressure: out_ready=0; push 3, 9, then offer 12 -> in_ready=0 after the second push and 12 is not accepted; out_ready=1 -> delivers 16'h0008 then 16'h0200, with dec_count=2.
REQ-035 Simultaneous push/pop in ONE: head=4'd15, push 4'd0 and pop together -> delivers 16'h8000, then the next cycle shows 16'h0001, with state remaining ONE.
REQ-036 Enable gating: enable=0 with one entry stored -> in_ready=0; the stored entry still drains on out_ready=1, and the FIFO then stays EMPTY despite in_valid=1.
REQ-037 Saturation: stream 300 codes with out_ready=1 -> dec_count stops at 255 and every decoder_out matches its code.
REQ-038 Reset mid-operation: FULL with 7 and 2 stored, assert reset_n=0 between clock edges -> out_valid=0 and decoder_out=16'h0000 immediately, and dec_count=0; after release nothing is delivered until a new push.

Source files
------------

// File: rtl/pri_decoder_buffered.sv
// pri_decoder_buffered: 4-to-16 one-hot decoder behind a 2-entry ready/valid FIFO
module pri_decoder_buffered (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  binary_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] decoder_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  dec_count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t     state_q, state_d;
  logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0] mem_q [2];
  logic [3:0] mem_d [2];
  logic [7:0] cnt_q, cnt_d;
  logic       push, pop;
  // handshakes, next-state and decoded head; outputs depend only on registered state
  always_comb begin
    in_ready    = reset_n & enable & (state_q != FULL);
    out_valid   = state_q != EMPTY;
    decoder_out = out_valid ? 16'h0001 << mem_q[rd_ptr_q] : 16'h0000;
    dec_count   = cnt_q;
    push        = in_valid & in_ready;
    pop         = out_valid & out_ready;
    state_d     = (push & ~pop) ? state_t'(state_q + 2'd1) : (pop & ~push) ? state_t'(state_q - 2'd1) : state_q;
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    mem_d       = mem_q;
    if (push) mem_d[wr_ptr_q] = binary_in;
    cnt_d       = (pop && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
  end
  // control state with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  // payload storage is never cleared; it is masked whenever out_valid is low
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
